// File: rtl/fb_raster_reader_pkg.sv
// Shared gfx definitions for the framebuffer read path: geometry defaults,
// pixel type, buffer base addressing and AXI response codes.
package fb_raster_reader_pkg;

  localparam int FB_WIDTH_DEF       = 640;
  localparam int FB_HEIGHT_DEF      = 480;
  localparam int AXI_ADDR_WIDTH_DEF = 20;
  localparam int AXI_DATA_WIDTH_DEF = 16;
  localparam int PIXEL_BITS_DEF     = 12;
  localparam int FIFO_DEPTH_DEF     = 4;

  localparam int BUF1_BASE_DEF = FB_WIDTH_DEF * FB_HEIGHT_DEF;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef logic [PIXEL_BITS_DEF-1:0] pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  // Buffer 1 sits directly after buffer 0 in word-addressed SRAM.
  function automatic logic [31:0] buf_base(input logic sel, input int width, input int height);
    return sel ? 32'(width * height) : 32'd0;
  endfunction

endpackage

// File: rtl/fb_raster_reader_sync_fifo.sv
// Small synchronous FIFO with registered storage; output word is visible the
// cycle after it is pushed and exposes its fill count for credit tracking.
module fb_raster_reader_sync_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // A pop on an empty FIFO is a no-op; a push on a full FIFO only lands when a pop frees a slot.
  assign do_pop_s  = pop && (count_r != {CW{1'b0}});
  assign do_push_s = push && ((count_r != CW'(DEPTH)) || do_pop_s);

  // Storage array; contents are don't-care until a pointer covers them.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign valid = (count_r != {CW{1'b0}});
  assign count = count_r;

endmodule

// File: rtl/fb_raster_reader.sv
// Framebuffer read side: walks the selected buffer in raster order, issues
// credit-limited AXI-lite reads and streams the returned pixels to the VGA path.
module fb_raster_reader
  import fb_raster_reader_pkg::*;
#(
  parameter int FB_WIDTH       = FB_WIDTH_DEF,
  parameter int FB_HEIGHT      = FB_HEIGHT_DEF,
  parameter int AXI_ADDR_WIDTH = AXI_ADDR_WIDTH_DEF,
  parameter int AXI_DATA_WIDTH = AXI_DATA_WIDTH_DEF,
  parameter int PIXEL_BITS     = PIXEL_BITS_DEF,
  parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_start,
  input  logic                      buf_sel,
  output logic                      busy,
  output logic                      rd_err,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  output logic                      pix_valid,
  input  logic                      pix_ready,
  output logic [PIXEL_BITS-1:0]     pix_data,
  output logic                      pix_last
);

  localparam int XW = $clog2(FB_WIDTH);
  localparam int YW = $clog2(FB_HEIGHT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [XW-1:0]             X_LAST    = XW'(FB_WIDTH - 1);
  localparam logic [YW-1:0]             Y_LAST    = YW'(FB_HEIGHT - 1);
  localparam logic [AXI_ADDR_WIDTH-1:0] BEAT_LAST = AXI_ADDR_WIDTH'(FB_WIDTH * FB_HEIGHT - 1);

  rd_state_e                 state_r, state_nxt_s;
  logic                      busy_r;
  logic                      rd_err_r;
  logic [XW-1:0]             x_r;
  logic [YW-1:0]             y_r;
  logic [AXI_ADDR_WIDTH-1:0] araddr_r;
  logic [AXI_ADDR_WIDTH-1:0] beat_r;
  logic [CW-1:0]             outst_r;
  logic [CW-1:0]             fifo_count_s;
  logic [PIXEL_BITS:0]       fifo_dout_s;
  logic                      fifo_valid_s;
  logic                      start_s, credit_s, arvalid_s, ar_hs_s, r_hs_s, last_beat_s, pop_last_s;

  assign start_s     = (state_r == ST_IDLE) && frame_start;
  // Outstanding reads plus buffered pixels never exceed the FIFO, so every R beat has a slot.
  assign credit_s    = (({1'b0, outst_r} + {1'b0, fifo_count_s}) < (CW + 1)'(FIFO_DEPTH));
  assign arvalid_s   = (state_r == ST_ISSUE) && credit_s;
  assign ar_hs_s     = arvalid_s && m_axi_arready;
  assign r_hs_s      = m_axi_rvalid && busy_r;
  assign last_beat_s = (beat_r == BEAT_LAST);
  assign pop_last_s  = fifo_valid_s && pix_ready && fifo_dout_s[PIXEL_BITS];

  // Next-state logic of the frame sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (frame_start) state_nxt_s = ST_ISSUE;
        else             state_nxt_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (ar_hs_s && (x_r == X_LAST) && (y_r == Y_LAST)) state_nxt_s = ST_DRAIN;
        else                                               state_nxt_s = ST_ISSUE;
      end
      ST_DRAIN: begin
        if (pop_last_s) state_nxt_s = ST_IDLE;
        else            state_nxt_s = ST_DRAIN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Sequencer state and busy flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
    end
  end

  // Raster address generator: running address counter alongside x/y.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      araddr_r <= {AXI_ADDR_WIDTH{1'b0}};
      x_r      <= {XW{1'b0}};
      y_r      <= {YW{1'b0}};
    end else if (start_s) begin
      araddr_r <= AXI_ADDR_WIDTH'(buf_base(buf_sel, FB_WIDTH, FB_HEIGHT));
      x_r      <= {XW{1'b0}};
      y_r      <= {YW{1'b0}};
    end else if (ar_hs_s) begin
      araddr_r <= araddr_r + AXI_ADDR_WIDTH'(1'b1);
      if (x_r == X_LAST) begin
        x_r <= {XW{1'b0}};
        y_r <= y_r + YW'(1'b1);
      end else begin
        x_r <= x_r + XW'(1'b1);
      end
    end
  end

  // Outstanding-read credit counter and per-frame beat counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outst_r <= {CW{1'b0}};
      beat_r  <= {AXI_ADDR_WIDTH{1'b0}};
    end else begin
      case ({ar_hs_s, r_hs_s})
        2'b10:   outst_r <= outst_r + CW'(1'b1);
        2'b01:   outst_r <= outst_r - CW'(1'b1);
        default: outst_r <= outst_r;
      endcase
      if (start_s) begin
        beat_r <= {AXI_ADDR_WIDTH{1'b0}};
      end else if (r_hs_s) begin
        beat_r <= beat_r + AXI_ADDR_WIDTH'(1'b1);
      end
    end
  end

  // Sticky read-error flag, cleared at each frame start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_err_r <= 1'b0;
    end else if (start_s) begin
      rd_err_r <= 1'b0;
    end else if (r_hs_s && (m_axi_rresp != RESP_OKAY)) begin
      rd_err_r <= 1'b1;
    end
  end

  fb_raster_reader_sync_fifo #(
    .WIDTH (PIXEL_BITS + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_pix_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (r_hs_s),
    .din   ({last_beat_s, m_axi_rdata[PIXEL_BITS-1:0]}),
    .pop   (pix_ready),
    .dout  (fifo_dout_s),
    .valid (fifo_valid_s),
    .count (fifo_count_s)
  );

  generate
    if (AXI_DATA_WIDTH > PIXEL_BITS) begin : g_rdata_pad
      logic rdata_unused_s;
      assign rdata_unused_s = ^m_axi_rdata[AXI_DATA_WIDTH-1:PIXEL_BITS];
    end
  endgenerate

  assign busy          = busy_r;
  assign rd_err        = rd_err_r;
  assign m_axi_araddr  = araddr_r;
  assign m_axi_arvalid = arvalid_s;
  assign m_axi_rready  = busy_r;
  assign pix_valid     = fifo_valid_s;
  assign pix_data      = fifo_dout_s[PIXEL_BITS-1:0];
  assign pix_last      = fifo_dout_s[PIXEL_BITS];

endmodule

// File: tb/tb_fb_raster_reader.sv
// Randomized bench for fb_raster_reader on a 4x2 frame: a behavioural SRAM
// slave plus an expected address/pixel list derived from raster order.
module tb_fb_raster_reader;

  localparam int W = 4;
  localparam int H = 2;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        buf_sel = 1'b0;
  logic        busy, rd_err;
  logic [19:0] m_axi_araddr;
  logic        m_axi_arvalid;
  logic        m_axi_arready = 1'b0;
  logic [15:0] m_axi_rdata = 16'h0000;
  logic [1:0]  m_axi_rresp = 2'b00;
  logic        m_axi_rvalid = 1'b0;
  logic        m_axi_rready;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic [11:0] pix_data;
  logic        pix_last;

  fb_raster_reader #(
    .FB_WIDTH(W), .FB_HEIGHT(H), .AXI_ADDR_WIDTH(20),
    .AXI_DATA_WIDTH(16), .PIXEL_BITS(12), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .buf_sel(buf_sel),
    .busy(busy), .rd_err(rd_err),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_last(pix_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] addr;
    int          due;
  } rreq_t;

  logic [15:0] sram [2*NPIX];
  rreq_t       r_q[$];
  logic [19:0] exp_addr_q[$];
  logic [12:0] exp_pix_q[$];

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int r_beat = 0;
  int frame_ar = 0;
  int err_beat = -1;
  int r_delay = 1;
  int ar_hold = 0;
  int pix_mode = 0;   // 0 always ready, 1 never, 2 random
  bit ar_rand = 1'b0;
  bit fs_pending = 1'b0;
  bit fs_sel = 1'b0;
  bit r_hs_prev = 1'b0;
  bit ar_wait_prev = 1'b0;
  bit pix_wait_prev = 1'b0;
  logic [19:0] ar_addr_prev;
  logic [12:0] pix_prev;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock of slave/sink behaviour; all handshakes are decided at the negedge.
  task automatic step();
    @(negedge clk);
    cyc++;
    frame_start = fs_pending;
    if (fs_pending) buf_sel = fs_sel;
    fs_pending = 1'b0;
    if (r_hs_prev) begin
      void'(r_q.pop_front());
      m_axi_rvalid = 1'b0;
      r_beat++;
    end
    if (!m_axi_rvalid && (r_q.size() != 0) && (r_q[0].due <= cyc)) begin
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = sram[r_q[0].addr[3:0]];
      m_axi_rresp  = (r_beat == err_beat) ? 2'b10 : 2'b00;
    end
    case (pix_mode)
      0:       pix_ready = 1'b1;
      1:       pix_ready = 1'b0;
      default: pix_ready = 1'($urandom_range(0, 1));
    endcase
    if ((ar_hold > 0) && m_axi_arvalid) begin
      m_axi_arready = 1'b0;
      ar_hold--;
    end else if (ar_rand) begin
      m_axi_arready = 1'($urandom_range(0, 1));
    end else begin
      m_axi_arready = 1'b1;
    end
    if (ar_wait_prev) begin
      check_eq("araddr_hold", m_axi_araddr, ar_addr_prev);
      check_eq("arvalid_hold", m_axi_arvalid, 1'b1);
    end
    if (pix_wait_prev) check_eq("pix_hold", {pix_last, pix_data}, pix_prev);
    if (m_axi_arvalid && m_axi_arready) begin
      check_eq("ar_expected", exp_addr_q.size() != 0, 1'b1);
      if (exp_addr_q.size() != 0) check_eq("araddr", m_axi_araddr, exp_addr_q.pop_front());
      r_q.push_back('{addr: m_axi_araddr, due: cyc + r_delay});
      frame_ar++;
    end
    r_hs_prev = m_axi_rvalid && m_axi_rready;
    if (pix_valid && pix_ready) begin
      check_eq("pix_expected", exp_pix_q.size() != 0, 1'b1);
      if (exp_pix_q.size() != 0) check_eq("pixel", {pix_last, pix_data}, exp_pix_q.pop_front());
    end
    ar_wait_prev  = m_axi_arvalid && !m_axi_arready;
    ar_addr_prev  = m_axi_araddr;
    pix_wait_prev = pix_valid && !pix_ready;
    pix_prev      = {pix_last, pix_data};
  endtask

  // Reference: raster order over the selected buffer, last flag on pixel W*H.
  task automatic start_frame(input bit sel);
    int base;
    base = sel ? NPIX : 0;
    fs_pending = 1'b1;
    fs_sel = sel;
    r_beat = 0;
    frame_ar = 0;
    exp_addr_q.delete();
    exp_pix_q.delete();
    for (int i = 0; i < NPIX; i++) begin
      exp_addr_q.push_back(20'(base + i));
      exp_pix_q.push_back({(i == NPIX - 1) ? 1'b1 : 1'b0, sram[base + i][11:0]});
    end
    step();
    step();
    check_eq("start_busy", busy, 1'b1);
    check_eq("start_rd_err", rd_err, 1'b0);
    if (ar_hold == 0) check_eq("start_arvalid", m_axi_arvalid, 1'b1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((exp_pix_q.size() != 0) && (n < 400)) begin
      step();
      n++;
    end
    check_eq({tag, "_timeout"}, n < 400, 1'b1);
    exp_pix_q.delete();
    step();
    check_eq({tag, "_busy_low"}, busy, 1'b0);
    check_eq({tag, "_ar_left"}, exp_addr_q.size(), 0);
    check_eq({tag, "_arvalid_low"}, m_axi_arvalid, 1'b0);
    exp_addr_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_rd_err"}, rd_err, 1'b0);
    check_eq({tag, "_arvalid"}, m_axi_arvalid, 1'b0);
    check_eq({tag, "_araddr"}, m_axi_araddr, 20'h0);
    check_eq({tag, "_rready"}, m_axi_rready, 1'b0);
    check_eq({tag, "_pix_valid"}, pix_valid, 1'b0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2 * NPIX; i++) sram[i] = 16'($urandom);
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;

    // Plain frame from buffer 0.
    start_frame(1'b0);
    wait_done("f0");

    // Buffer 1, with buf_sel and frame_start disturbed mid-frame.
    start_frame(1'b1);
    repeat (3) step();
    fs_pending = 1'b1;
    fs_sel = 1'b0;
    step();
    wait_done("f1");

    // Stalled sink: credit stops issue at FIFO depth.
    pix_mode = 1;
    start_frame(1'b0);
    repeat (20) step();
    check_eq("credit_ar_count", frame_ar, 4);
    check_eq("credit_arvalid", m_axi_arvalid, 1'b0);
    check_eq("credit_pix_valid", pix_valid, 1'b1);
    pix_mode = 0;
    wait_done("credit");

    // Slow address channel and late data.
    ar_hold = 3;
    r_delay = 5;
    start_frame(1'b1);
    wait_done("slow");
    r_delay = 1;

    // Error response on the third beat: pixel still delivered, flag sticky.
    err_beat = 2;
    start_frame(1'b0);
    wait_done("err");
    check_eq("rd_err_set", rd_err, 1'b1);
    err_beat = -1;

    // Randomized handshakes.
    ar_rand = 1'b1;
    pix_mode = 2;
    for (int f = 0; f < 4; f++) begin
      r_delay = $urandom_range(1, 4);
      start_frame(1'($urandom_range(0, 1)));
      wait_done("rand");
    end
    ar_rand = 1'b0;
    pix_mode = 0;
    r_delay = 1;

    // Reset mid-frame after three accepted reads.
    err_beat = 0;
    start_frame(1'b1);
    n = 0;
    while ((frame_ar < 3) && (n < 50)) begin
      step();
      n++;
    end
    check_eq("mid_reset_reach", frame_ar, 3);
    @(posedge clk);
    #1;
    check_eq("mid_rd_err", rd_err, 1'b1);
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    r_q.delete();
    exp_addr_q.delete();
    exp_pix_q.delete();
    m_axi_rvalid = 1'b0;
    frame_start = 1'b0;
    r_hs_prev = 1'b0;
    ar_wait_prev = 1'b0;
    pix_wait_prev = 1'b0;
    err_beat = -1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    start_frame(1'b0);
    wait_done("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
